// File: rtl/ifetch_unit_pkg.sv
// rtl/ifetch_unit_pkg.sv - shared constants and helpers for the instruction fetch front end
package ifetch_unit_pkg;

  localparam logic [31:0] TEXT_BASE_ADDRESS = 32'h0000_3000;
  localparam int          IF_DEPTH_DEFAULT  = 2;
  localparam int          IF_ENTRY_W        = 64;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifetch_unit_inst_fifo.sv
// rtl/ifetch_unit_inst_fifo.sv - registered instruction buffer holding {pc, inst} entries
module inst_fifo
  import ifetch_unit_pkg::*;
#(
  parameter int DEPTH = IF_DEPTH_DEFAULT,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [IF_ENTRY_W-1:0] push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [IF_ENTRY_W-1:0] head_data,
  output logic                  full,
  output logic                  empty,
  output logic [CW-1:0]         count
);

  logic [IF_ENTRY_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  w_pop_ok;
  logic                  w_push_ok;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));
  assign count     = r_count;
  assign head_data = r_mem[r_rd_ptr];

  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && (!full || w_pop_ok);

  // Entries are cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - fetch PC, request credits and stale-response dropping for instruction memory
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = TEXT_BASE_ADDRESS,
  parameter int          DEPTH    = IF_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_data,
  input  logic        inst_ready,
  output logic        busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]           r_fetch_pc;
  logic [31:0]           r_resp_pc;
  logic [CW-1:0]         r_outstanding;
  logic [CW-1:0]         r_drop_cnt;

  logic [CW-1:0]         w_count;
  logic                  w_full;
  logic                  w_empty;
  logic [IF_ENTRY_W-1:0] w_head;
  logic [CW:0]           w_in_use;
  logic                  w_credit_ok;
  logic                  w_grant;
  logic                  w_resp;
  logic                  w_push;
  logic                  w_pop;
  logic [CW-1:0]         w_out_next;
  logic [31:0]           w_redirect_pc;

  assign w_in_use    = {1'b0, r_outstanding} + {1'b0, w_count};
  assign w_credit_ok = (w_in_use < (CW + 1)'(DEPTH)) && !w_full;

  // Credits only shrink through grants, so a raised request holds until granted.
  assign imem_req   = w_credit_ok && !redirect_valid && !rst;
  assign imem_addr  = word_align(r_fetch_pc);

  assign w_grant    = imem_req && imem_gnt;
  assign w_resp     = imem_rvalid && (r_outstanding != '0);
  assign w_push     = w_resp && (r_drop_cnt == '0) && !redirect_valid;
  assign w_pop      = inst_valid && inst_ready;
  assign w_out_next = r_outstanding + CW'(w_grant) - CW'(w_resp);

  assign w_redirect_pc = word_align(redirect_pc);

  assign inst_valid = !w_empty;
  assign inst_pc    = w_head[63:32];
  assign inst_data  = w_head[31:0];
  assign busy       = (r_outstanding != '0) || (w_count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (redirect_valid) begin
        // Everything still in flight after this cycle belongs to the old path.
        r_fetch_pc <= w_redirect_pc;
        r_resp_pc  <= w_redirect_pc;
        r_drop_cnt <= w_out_next;
      end else begin
        if (w_grant) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_push)  r_resp_pc  <= r_resp_pc + 32'd4;
        if (w_resp && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - 1'b1;
      end
    end
  end

  inst_fifo #(
    .DEPTH (DEPTH)
  ) u_inst_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data ({r_resp_pc, imem_rdata}),
    .pop       (w_pop),
    .flush     (redirect_valid),
    .head_data (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Sequential fetch front end that consumes the next-PC value produced by the branch/jump target logic and turns it into instruction-memory reads.
- Holds the architectural fetch PC and issues pipelined requests to instruction memory over a req/gnt/rvalid protocol.
- Buffers returned words with their PCs and hands them to decode over a valid/ready interface.
- Accepts redirects (taken branch, jump, jr) and discards any stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_3000: fetch PC after reset; equals TEXT_BASE_ADDRESS.
- DEPTH, 2: instruction buffer entries; also the cap on outstanding requests plus buffered words. Legal values 2 or 4.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request valid
- imem_addr  out  32  word-aligned fetch address
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid; responses return in order
- imem_rdata  in  32  instruction word
- redirect_valid  in  1  load a new fetch PC this cycle
- redirect_pc  in  32  target from the next-PC logic
- inst_valid  out  1  buffered instruction available
- inst_pc  out  32  PC of the instruction at the buffer head
- inst_data  out  32  instruction at the buffer head
- inst_ready  in  1  decode consumes the head entry
- busy  out  1  requests outstanding or buffer non-empty

Behaviour:
- Reset (async, immediate):
  - fetch_pc = RESET_PC, resp_pc = RESET_PC.
  - outstanding = 0, drop_cnt = 0, buffer empty.
  - imem_req = 0, inst_valid = 0, inst_pc = 0, inst_data = 0, busy = 0.
- Credits:
  - credit_ok = (outstanding + count) < DEPTH.
  - imem_req = credit_ok && !redirect_valid && !rst.
  - imem_addr = {fetch_pc[31:2], 2'b00}.
- Request rules:
  - Once raised, imem_req and imem_addr stay stable until imem_gnt.
  - The only exception is a redirect, which may withdraw or retarget a pending request.
- Grant (imem_req && imem_gnt): fetch_pc += 4, wrapping modulo 2^32; outstanding += 1.
- Response (imem_rvalid):
  - outstanding -= 1.
  - If drop_cnt > 0: drop_cnt -= 1 and the word is discarded.
  - Otherwise: push {resp_pc, imem_rdata} into the buffer and resp_pc += 4.
  - An rvalid arriving while outstanding == 0 is ignored; no counters change.
- Latency: rvalid at cycle t gives inst_valid at t+1 (registered buffer, no fall-through). Grant to rvalid latency is set by memory, minimum 1 cycle.
- Pop: the head is consumed when inst_valid && inst_ready. A simultaneous push and pop keeps count unchanged.
- Credit accounting guarantees the buffer never overflows. A push into a full buffer is an assertion failure.
- Redirect (redirect_valid):
  - fetch_pc = resp_pc = {redirect_pc[31:2], 2'b00}.
  - The buffer is flushed. A same-cycle pop and push are both cancelled.
  - drop_cnt = outstanding after this cycle's grant and response updates, so a same-cycle grant counts as dropped.
  - imem_req = 0 in the redirect cycle; requesting from the new PC starts the next cycle.
  - Back-to-back redirects: the last one wins, and drop_cnt accumulates correctly.
- busy = (outstanding != 0) || (count != 0).
- Counter widths: outstanding and drop_cnt use $clog2(DEPTH)+1 bits.

Decomposition:
- Shared package / define file (ctrl_encode_def):
  - Add `IF_DEPTH_DEFAULT`.
  - Reuse the existing TEXT_BASE_ADDRESS define as the RESET_PC default.
- Sub-module inst_fifo: synchronous FIFO with async active-high reset, 64-bit entries {pc, inst}.
  - Ports: push, pop, flush, full, empty, count.
  - ifetch_unit contains credit, PC and drop logic only.

Test Plan:
- Reset release, zero-wait memory (gnt=1, rvalid 1 cycle later), inst_ready=1 → addresses 0x3000, 0x3004, 0x3008…; first inst_valid 2 cycles after the first req, inst_pc=0x3000.
- inst_ready=0 with memory always granting → exactly DEPTH grants, then imem_req=0. Raise inst_ready → words pop in order 0x3000, 0x3004, and requests resume one per freed credit.
- Two requests outstanding (0x3000, 0x3004), redirect_pc=0x3400 → both responses dropped. Next request addr=0x3400, next inst_pc=0x3400, with no stale inst_valid.
- Redirect in the same cycle as a grant and a response, redirect_pc=0x3013 → aligned to 0x3010. drop_cnt covers the granted request, and the buffer is empty the next cycle.
- imem_gnt held low for 3 cycles → imem_req and imem_addr stay stable. Assert rst mid-transaction → outputs clear immediately, and a later stray rvalid is ignored.
- fetch_pc = 0xFFFF_FFFC, grant → next imem_addr = 0x0000_0000 (wrap-around).
